// File: rtl/johnson_pkg.sv
`default_nettype none
// ============================================================================
// Package     : johnson_pkg
// Description : Shared types and helpers for decoding an N-bit Johnson
//               counter (shift left, inverted MSB into the LSB, 2N phases).
//               The helpers take the active width n at run time and operate
//               on a fixed c_MAX_N-bit container so that every user can share
//               one implementation. Bits at and above n are always zero.
// Revision    : 1.0 - initial release
// ============================================================================
package johnson_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam int c_MAX_N = 16;

    // Canonical code for phase k: k < n -> low k bits set,
    // k >= n -> high (2n-k) bits set (bit positions k-n .. n-1).
    function automatic logic [c_MAX_N-1:0] johnson_code(input int k, input int n);
        logic [c_MAX_N-1:0] r;
        r = '0;
        for (int i = 0; i < c_MAX_N; i++) begin
            if (i < n) begin
                if (k < n) r[i] = (i < k);
                else       r[i] = (i >= (k - n));
            end
        end
        return r;
    endfunction

    // Successor code: shift left by one, inverted MSB enters at bit 0.
    function automatic logic [c_MAX_N-1:0] johnson_next(input logic [c_MAX_N-1:0] code,
                                                         input int n);
        logic [c_MAX_N-1:0] r;
        logic               msb;
        r   = '0;
        msb = 1'b0;
        for (int i = 0; i < c_MAX_N; i++) begin
            if (i == n - 1) msb = code[i];
        end
        for (int i = 1; i < c_MAX_N; i++) begin
            if (i < n) r[i] = code[i-1];
        end
        r[0] = ~msb;
        return r;
    endfunction

    function automatic logic johnson_legal(input logic [c_MAX_N-1:0] code, input int n);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < 2 * c_MAX_N; k++) begin
            if ((k < 2 * n) && (code == johnson_code(k, n))) hit = 1'b1;
        end
        return hit;
    endfunction

    // Phase index of a legal code; 0 for an illegal one.
    function automatic int johnson_idx(input logic [c_MAX_N-1:0] code, input int n);
        int r;
        r = 0;
        for (int k = 0; k < 2 * c_MAX_N; k++) begin
            if ((k < 2 * n) && (code == johnson_code(k, n))) r = k;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/johnson_phase_decoder_if.sv
`default_nettype none
// ============================================================================
// Interface   : johnson_phase_decoder_if
// Description : Bundle between a Johnson counter source and the phase
//               decoder.
//               master : drives count / err_clr, observes decoder results.
//               slave  : the decoder; samples count / err_clr, drives
//                        phase_idx, phase_onehot, phase_valid, locked,
//                        err_pulse, err_sticky, wrap_pulse, rev_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
interface johnson_phase_decoder_if #(
    parameter int N     = 4,
    parameter int REV_W = 8
);
    localparam int c_PH = 2 * N;
    localparam int c_IW = $clog2(c_PH);

    logic [N-1:0]     count;
    logic             err_clr;
    logic [c_IW-1:0]  phase_idx;
    logic [c_PH-1:0]  phase_onehot;
    logic             phase_valid;
    logic             locked;
    logic             err_pulse;
    logic             err_sticky;
    logic             wrap_pulse;
    logic [REV_W-1:0] rev_cnt;

    modport master (
        output count, err_clr,
        input  phase_idx, phase_onehot, phase_valid, locked,
               err_pulse, err_sticky, wrap_pulse, rev_cnt
    );

    modport slave (
        input  count, err_clr,
        output phase_idx, phase_onehot, phase_valid, locked,
               err_pulse, err_sticky, wrap_pulse, rev_cnt
    );
endinterface
`default_nettype wire

// File: rtl/johnson_code_check.sv
`default_nettype none
// ============================================================================
// Module      : johnson_code_check
// Description : Combinational classifier for one Johnson code sample.
//   i_cur      : current code
//   i_prev     : previous code (reference)
//   o_legal    : i_cur is one of the 2N legal codes
//   o_idx      : phase index of i_cur (0 when illegal)
//   o_onehot   : one-hot of o_idx, all zero when illegal
//   o_is_step  : i_cur is the Johnson successor of a legal i_prev
// Revision    : 1.0 - initial release
// ============================================================================
module johnson_code_check
    import johnson_pkg::*;
#(
    parameter int N = 4
) (
    input  wire logic [N-1:0]               i_cur,
    input  wire logic [N-1:0]               i_prev,
    output logic                            o_legal,
    output logic [$clog2(2*N)-1:0]          o_idx,
    output logic [2*N-1:0]                  o_onehot,
    output logic                            o_is_step
);
    localparam int c_PH = 2 * N;
    localparam int c_IW = $clog2(c_PH);

    logic [c_MAX_N-1:0] w_cur_ext;
    logic [c_MAX_N-1:0] w_prev_ext;

    assign w_cur_ext  = c_MAX_N'(i_cur);
    assign w_prev_ext = c_MAX_N'(i_prev);

    assign o_legal   = johnson_legal(w_cur_ext, N);
    assign o_idx     = c_IW'(johnson_idx(w_cur_ext, N));
    assign o_onehot  = o_legal ? (c_PH'(1) << o_idx) : '0;
    // The successor of an illegal code is never treated as a step.
    assign o_is_step = johnson_legal(w_prev_ext, N) &&
                       (johnson_next(w_prev_ext, N) == w_cur_ext);
endmodule
`default_nettype wire

// File: rtl/johnson_phase_decoder.sv
`default_nettype none
// ============================================================================
// Module      : johnson_phase_decoder
// Description : Validates and decodes a Johnson counter bus. Produces a
//               registered phase index / one-hot strobe, tracks sequencing
//               with a SEARCH/TRACK/LOCKED machine, flags errors and counts
//               full revolutions while locked. All outputs have latency 1.
//   clk    : rising-edge clock
//   reset  : synchronous active-high reset
//   bus    : johnson_phase_decoder_if slave (count, err_clr in; results out)
// Revision    : 1.0 - initial release
// ============================================================================
module johnson_phase_decoder
    import johnson_pkg::*;
#(
    parameter int N          = 4,
    parameter int LOCK_STEPS = 4,
    parameter int REV_W      = 8,
    parameter bit ALLOW_HOLD = 1'b1
) (
    input  wire logic              clk,
    input  wire logic              reset,
    johnson_phase_decoder_if.slave bus
);
    localparam int c_PH = 2 * N;
    localparam int c_IW = $clog2(c_PH);
    localparam int c_GW = $clog2(LOCK_STEPS + 1);

    state_t           r_state;
    state_t           w_state_n;
    logic [c_GW-1:0]  r_good;
    logic [c_GW-1:0]  w_good_n;
    logic [c_GW-1:0]  w_good_inc;
    logic [N-1:0]     r_prev;

    logic [c_IW-1:0]  r_phase_idx;
    logic [c_PH-1:0]  r_phase_onehot;
    logic             r_phase_valid;
    logic             r_locked;
    logic             r_err_pulse;
    logic             r_err_sticky;
    logic             r_wrap_pulse;
    logic [REV_W-1:0] r_rev_cnt;

    logic             w_legal;
    logic [c_IW-1:0]  w_idx;
    logic [c_PH-1:0]  w_onehot;
    logic             w_is_step;
    logic             w_hold_ok;
    logic             w_err;
    logic             w_wrap;

    johnson_code_check #(.N(N)) u_check (
        .i_cur     (bus.count),
        .i_prev    (r_prev),
        .o_legal   (w_legal),
        .o_idx     (w_idx),
        .o_onehot  (w_onehot),
        .o_is_step (w_is_step)
    );

    assign w_hold_ok  = ALLOW_HOLD && (bus.count == r_prev);
    assign w_good_inc = r_good + c_GW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= SEARCH;
            r_good  <= '0;
        end else begin
            r_state <= w_state_n;
            r_good  <= w_good_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_good_n  = r_good;
        w_err     = 1'b0;
        w_wrap    = 1'b0;
        case (r_state)
            SEARCH: begin
                // No reference yet: only legality matters.
                if (w_legal) begin
                    w_state_n = TRACK;
                    w_good_n  = '0;
                end else begin
                    w_err = 1'b1;
                end
            end
            TRACK: begin
                if (!w_legal) begin
                    w_err     = 1'b1;
                    w_state_n = SEARCH;
                end else if (w_is_step) begin
                    w_good_n = w_good_inc;
                    if (w_good_inc == c_GW'(LOCK_STEPS)) w_state_n = LOCKED;
                end else if (!w_hold_ok) begin
                    // Bad move or forbidden hold: current code becomes the new reference.
                    w_err    = 1'b1;
                    w_good_n = '0;
                end
            end
            LOCKED: begin
                if (!w_legal) begin
                    w_err     = 1'b1;
                    w_state_n = SEARCH;
                end else if (w_is_step) begin
                    // A step landing on phase 0 must have come from phase 2N-1.
                    w_wrap = (w_idx == '0);
                end else if (!w_hold_ok) begin
                    w_err     = 1'b1;
                    w_state_n = TRACK;
                    w_good_n  = '0;
                end
            end
            default: begin
                w_state_n = SEARCH;
                w_good_n  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev         <= '0;
            r_phase_idx    <= '0;
            r_phase_onehot <= '0;
            r_phase_valid  <= 1'b0;
            r_locked       <= 1'b0;
            r_err_pulse    <= 1'b0;
            r_err_sticky   <= 1'b0;
            r_wrap_pulse   <= 1'b0;
            r_rev_cnt      <= '0;
        end else begin
            r_prev         <= bus.count;
            if (w_legal) r_phase_idx <= w_idx;
            r_phase_onehot <= w_onehot;
            r_phase_valid  <= w_legal;
            r_locked       <= (w_state_n == LOCKED);
            r_err_pulse    <= w_err;
            r_wrap_pulse   <= w_wrap;
            if (w_wrap) r_rev_cnt <= r_rev_cnt + REV_W'(1);
            // A new error wins over a clear in the same cycle.
            if (w_err)            r_err_sticky <= 1'b1;
            else if (bus.err_clr) r_err_sticky <= 1'b0;
        end
    end

    assign bus.phase_idx    = r_phase_idx;
    assign bus.phase_onehot = r_phase_onehot;
    assign bus.phase_valid  = r_phase_valid;
    assign bus.locked       = r_locked;
    assign bus.err_pulse    = r_err_pulse;
    assign bus.err_sticky   = r_err_sticky;
    assign bus.wrap_pulse   = r_wrap_pulse;
    assign bus.rev_cnt      = r_rev_cnt;
endmodule
`default_nettype wire

// File: tb/tb_johnson_phase_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_johnson_phase_decoder
// Description : Self-checking bench for johnson_phase_decoder. Two instances
//               share the stimulus: one allowing holds, one forbidding them.
//               A reference model predicts every output per cycle into a
//               queue per instance; a monitor pops and compares after each
//               clock edge. Scenario tasks add direct checks against known
//               values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_johnson_phase_decoder;

    typedef struct packed {
        logic [2:0] idx;
        logic [7:0] oh;
        logic       valid;
        logic       locked;
        logic       err;
        logic       sticky;
        logic       wrap;
        logic [7:0] rev;
    } exp_t;

    localparam logic [3:0] SEQ [0:7] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                                         4'b1111, 4'b1110, 4'b1100, 4'b1000};

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] drv_count;
    logic       drv_clr;

    int checks = 0;
    int errors = 0;

    exp_t q0[$];
    exp_t q1[$];

    logic [3:0] m_prev   [2];
    int         m_state  [2];
    int         m_good   [2];
    logic [2:0] m_idx    [2];
    logic       m_sticky [2];
    logic [7:0] m_rev    [2];

    always #5 clk = ~clk;

    johnson_phase_decoder_if #(.N(4), .REV_W(8)) if_h ();
    johnson_phase_decoder_if #(.N(4), .REV_W(8)) if_n ();

    assign if_h.count   = drv_count;
    assign if_h.err_clr = drv_clr;
    assign if_n.count   = drv_count;
    assign if_n.err_clr = drv_clr;

    johnson_phase_decoder #(.N(4), .LOCK_STEPS(4), .REV_W(8), .ALLOW_HOLD(1'b1)) dut_h (
        .clk(clk), .reset(reset), .bus(if_h));
    johnson_phase_decoder #(.N(4), .LOCK_STEPS(4), .REV_W(8), .ALLOW_HOLD(1'b0)) dut_n (
        .clk(clk), .reset(reset), .bus(if_n));

    function automatic int find_phase(input logic [3:0] c);
        int r;
        r = -1;
        for (int i = 0; i < 8; i++) if (SEQ[i] == c) r = i;
        return r;
    endfunction

    // a = 0 : holds allowed, a = 1 : holds forbidden
    task automatic model(input int a, input logic r, input logic [3:0] c,
                         input logic clr, output exp_t e);
        int k, kp;
        bit lg, stp, hld, allow, er, wr;
        e = '0;
        if (r) begin
            m_prev[a] = 4'b0; m_state[a] = 0; m_good[a] = 0;
            m_idx[a] = 3'd0; m_sticky[a] = 1'b0; m_rev[a] = 8'd0;
        end else begin
            allow = (a == 0);
            k   = find_phase(c);
            kp  = find_phase(m_prev[a]);
            lg  = (k >= 0);
            stp = lg && (kp >= 0) && (((kp + 1) % 8) == k);
            hld = (c == m_prev[a]);
            er  = 1'b0;
            wr  = 1'b0;
            case (m_state[a])
                0: begin
                    if (lg) begin m_state[a] = 1; m_good[a] = 0; end
                    else er = 1'b1;
                end
                1: begin
                    if (!lg) begin er = 1'b1; m_state[a] = 0; end
                    else if (stp) begin
                        m_good[a] = m_good[a] + 1;
                        if (m_good[a] == 4) m_state[a] = 2;
                    end else if (!(hld && allow)) begin
                        er = 1'b1; m_good[a] = 0;
                    end
                end
                default: begin
                    if (!lg) begin er = 1'b1; m_state[a] = 0; end
                    else if (stp) begin
                        if (kp == 7) begin wr = 1'b1; m_rev[a] = m_rev[a] + 8'd1; end
                    end else if (!(hld && allow)) begin
                        er = 1'b1; m_state[a] = 1; m_good[a] = 0;
                    end
                end
            endcase
            if (lg) m_idx[a] = 3'(k);
            if (er) m_sticky[a] = 1'b1;
            else if (clr) m_sticky[a] = 1'b0;
            e.idx    = m_idx[a];
            e.oh     = lg ? (8'd1 << k) : 8'd0;
            e.valid  = lg;
            e.locked = (m_state[a] == 2);
            e.err    = er;
            e.sticky = m_sticky[a];
            e.wrap   = wr;
            e.rev    = m_rev[a];
            m_prev[a] = c;
        end
    endtask

    // One cycle of stimulus; returns one time unit after the sampling edge.
    task automatic drive(input logic r, input logic [3:0] c, input logic clr);
        exp_t e0, e1;
        @(negedge clk);
        reset     = r;
        drv_count = c;
        drv_clr   = clr;
        model(0, r, c, clr, e0);
        model(1, r, c, clr, e1);
        q0.push_back(e0);
        q1.push_back(e1);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor.
    initial begin
        exp_t e, got;
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) begin
                e = q0.pop_front();
                got = {if_h.phase_idx, if_h.phase_onehot, if_h.phase_valid, if_h.locked,
                       if_h.err_pulse, if_h.err_sticky, if_h.wrap_pulse, if_h.rev_cnt};
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL sb_allow_hold t=%0t got %h exp %h", $time, got, e);
                end
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                got = {if_n.phase_idx, if_n.phase_onehot, if_n.phase_valid, if_n.locked,
                       if_n.err_pulse, if_n.err_sticky, if_n.wrap_pulse, if_n.rev_cnt};
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL sb_no_hold t=%0t got %h exp %h", $time, got, e);
                end
            end
        end
    end

    task automatic test_reset();
        for (int i = 0; i < 3; i++) drive(1'b1, 4'b0000, 1'b0);
        checks++;
        if ({if_h.phase_idx, if_h.phase_onehot, if_h.phase_valid, if_h.locked} !== 13'd0) begin
            errors++;
            $display("FAIL reset_phase got idx=%0d oh=%h v=%b l=%b exp zeros",
                     if_h.phase_idx, if_h.phase_onehot, if_h.phase_valid, if_h.locked);
        end
        checks++;
        if ({if_h.err_pulse, if_h.err_sticky, if_h.wrap_pulse, if_h.rev_cnt} !== 11'd0) begin
            errors++;
            $display("FAIL reset_flags got e=%b s=%b w=%b rev=%0d exp zeros",
                     if_h.err_pulse, if_h.err_sticky, if_h.wrap_pulse, if_h.rev_cnt);
        end
    endtask

    task automatic test_lock_sequence();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, SEQ[i], 1'b0);
            checks++;
            if (if_h.phase_idx !== 3'(i) || if_h.phase_onehot !== (8'd1 << i)) begin
                errors++;
                $display("FAIL lock_seq_decode%0d got idx=%0d oh=%h exp idx=%0d oh=%h",
                         i, if_h.phase_idx, if_h.phase_onehot, i, 8'd1 << i);
            end
            checks++;
            if (if_h.locked !== (i == 4)) begin
                errors++;
                $display("FAIL lock_seq_locked%0d got %b exp %b", i, if_h.locked, (i == 4));
            end
        end
        checks++;
        if (if_h.err_sticky !== 1'b0) begin
            errors++;
            $display("FAIL lock_seq_sticky got %b exp 0", if_h.err_sticky);
        end
    endtask

    task automatic test_wrap();
        int p;
        for (int i = 5; i < 9; i++) begin
            drive(1'b0, SEQ[i % 8], 1'b0);
            checks++;
            if (if_h.wrap_pulse !== (i == 8)) begin
                errors++;
                $display("FAIL wrap_pulse%0d got %b exp %b", i, if_h.wrap_pulse, (i == 8));
            end
        end
        checks++;
        if (if_h.rev_cnt !== 8'd1) begin
            errors++;
            $display("FAIL wrap_rev1 got %0d exp 1", if_h.rev_cnt);
        end
        p = 0;
        for (int j = 0; j < 16; j++) begin
            p = (p + 1) % 8;
            drive(1'b0, SEQ[p], 1'b0);
            if (j == 0) begin
                checks++;
                if (if_h.wrap_pulse !== 1'b0) begin
                    errors++;
                    $display("FAIL wrap_single got %b exp 0", if_h.wrap_pulse);
                end
            end
        end
        checks++;
        if (if_h.rev_cnt !== 8'd3 || if_h.locked !== 1'b1) begin
            errors++;
            $display("FAIL wrap_rev3 got rev=%0d locked=%b exp rev=3 locked=1",
                     if_h.rev_cnt, if_h.locked);
        end
    endtask

    task automatic test_illegal();
        drive(1'b0, 4'b0101, 1'b0);
        checks++;
        if (if_h.phase_valid !== 1'b0 || if_h.phase_onehot !== 8'd0) begin
            errors++;
            $display("FAIL illegal_decode got v=%b oh=%h exp v=0 oh=00",
                     if_h.phase_valid, if_h.phase_onehot);
        end
        checks++;
        if (if_h.err_pulse !== 1'b1 || if_h.err_sticky !== 1'b1 || if_h.locked !== 1'b0) begin
            errors++;
            $display("FAIL illegal_flags got e=%b s=%b l=%b exp e=1 s=1 l=0",
                     if_h.err_pulse, if_h.err_sticky, if_h.locked);
        end
        for (int i = 1; i < 6; i++) begin
            drive(1'b0, SEQ[i], 1'b0);
            if (i == 1) begin
                checks++;
                if (if_h.err_pulse !== 1'b0) begin
                    errors++;
                    $display("FAIL illegal_pulse_len got %b exp 0", if_h.err_pulse);
                end
            end
            checks++;
            if (if_h.locked !== (i == 5)) begin
                errors++;
                $display("FAIL relock%0d got %b exp %b", i, if_h.locked, (i == 5));
            end
        end
    endtask

    task automatic test_jump();
        for (int i = 6; i < 11; i++) drive(1'b0, SEQ[i % 8], 1'b0);
        checks++;
        if (if_h.rev_cnt !== 8'd4 || if_h.locked !== 1'b1) begin
            errors++;
            $display("FAIL jump_pre got rev=%0d l=%b exp rev=4 l=1", if_h.rev_cnt, if_h.locked);
        end
        drive(1'b0, 4'b1111, 1'b0);
        checks++;
        if (if_h.err_pulse !== 1'b1 || if_h.locked !== 1'b0 || if_h.phase_idx !== 3'd4 ||
            if_h.rev_cnt !== 8'd4) begin
            errors++;
            $display("FAIL jump got e=%b l=%b idx=%0d rev=%0d exp e=1 l=0 idx=4 rev=4",
                     if_h.err_pulse, if_h.locked, if_h.phase_idx, if_h.rev_cnt);
        end
        // Four steps suffice only if the jump left the machine in TRACK.
        for (int i = 5; i < 9; i++) drive(1'b0, SEQ[i % 8], 1'b0);
        checks++;
        if (if_h.locked !== 1'b1 || if_h.wrap_pulse !== 1'b0 || if_h.rev_cnt !== 8'd4) begin
            errors++;
            $display("FAIL jump_relock got l=%b w=%b rev=%0d exp l=1 w=0 rev=4",
                     if_h.locked, if_h.wrap_pulse, if_h.rev_cnt);
        end
    endtask

    task automatic test_hold();
        drive(1'b0, 4'b0001, 1'b0);
        drive(1'b0, 4'b0011, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 4'b0011, 1'b0);
            checks++;
            if (if_h.err_pulse !== 1'b0 || if_h.locked !== 1'b1) begin
                errors++;
                $display("FAIL hold_allowed%0d got e=%b l=%b exp e=0 l=1",
                         i, if_h.err_pulse, if_h.locked);
            end
            if (i == 0) begin
                checks++;
                if (if_n.err_pulse !== 1'b1 || if_n.locked !== 1'b0) begin
                    errors++;
                    $display("FAIL hold_forbidden got e=%b l=%b exp e=1 l=0",
                             if_n.err_pulse, if_n.locked);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 3; i < 9; i++) drive(1'b0, SEQ[i % 8], 1'b0);
        drive(1'b0, 4'b0001, 1'b0);
        checks++;
        if (if_h.rev_cnt !== 8'd5 || if_h.locked !== 1'b1 ||
            if_n.rev_cnt !== 8'd5 || if_n.locked !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset got rev=%0d/%0d l=%b/%b exp rev=5 l=1",
                     if_h.rev_cnt, if_n.rev_cnt, if_h.locked, if_n.locked);
        end
        drive(1'b1, 4'b0011, 1'b0);
        checks++;
        if ({if_h.phase_idx, if_h.phase_onehot, if_h.phase_valid, if_h.locked, if_h.err_pulse,
             if_h.err_sticky, if_h.wrap_pulse, if_h.rev_cnt} !== 24'd0) begin
            errors++;
            $display("FAIL mid_reset got idx=%0d oh=%h l=%b s=%b rev=%0d exp zeros",
                     if_h.phase_idx, if_h.phase_onehot, if_h.locked, if_h.err_sticky,
                     if_h.rev_cnt);
        end
    endtask

    task automatic test_err_clr();
        drive(1'b0, 4'b0000, 1'b0);
        drive(1'b0, 4'b0110, 1'b1);
        checks++;
        if (if_h.err_sticky !== 1'b1 || if_h.err_pulse !== 1'b1) begin
            errors++;
            $display("FAIL clr_with_err got s=%b e=%b exp s=1 e=1", if_h.err_sticky,
                     if_h.err_pulse);
        end
        drive(1'b0, 4'b0000, 1'b0);
        checks++;
        if (if_h.err_sticky !== 1'b1) begin
            errors++;
            $display("FAIL sticky_hold got %b exp 1", if_h.err_sticky);
        end
        drive(1'b0, 4'b0001, 1'b1);
        checks++;
        if (if_h.err_sticky !== 1'b0 || if_h.err_pulse !== 1'b0) begin
            errors++;
            $display("FAIL clr_alone got s=%b e=%b exp s=0 e=0", if_h.err_sticky,
                     if_h.err_pulse);
        end
    endtask

    initial begin
        reset     = 1'b1;
        drv_count = 4'b0000;
        drv_clr   = 1'b0;
        test_reset();
        test_lock_sequence();
        test_wrap();
        test_illegal();
        test_jump();
        test_hold();
        test_reset_mid();
        test_err_clr();
        repeat (3) @(negedge clk);
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got %0d/%0d pending exp 0", q0.size(), q1.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/johnson_phase_decoder.md
Name: johnson_phase_decoder

Overview:
- Downstream consumer of the 4-bit Johnson counter's `count` bus.
- Decodes each Johnson code into a phase index and a one-hot phase strobe.
- Checks code legality and step-to-step sequencing, and keeps a lock state.
- Counts full revolutions, so later logic can use the counter as a validated multi-phase timing source.

Parameters:
- N, 4: Johnson counter width; the code has 2N phases.
- LOCK_STEPS, 4: consecutive legal advances required to declare lock.
- REV_W, 8: revolution counter width.
- ALLOW_HOLD, 1: 1 = repeated identical code is legal (counter stalled); 0 = repeat is a sequencing error.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- count  input  N  Johnson code from the counter, sampled every clk.
- err_clr  input  1  clears err_sticky.
- phase_idx  output  $clog2(2N)  decoded phase 0..2N-1.
- phase_onehot  output  2N  one-hot of phase_idx; all zero when code is illegal.
- phase_valid  output  1  current sample is a legal code.
- locked  output  1  state == LOCKED.
- err_pulse  output  1  one-cycle pulse on illegal code or illegal transition.
- err_sticky  output  1  latched error.
- wrap_pulse  output  1  one-cycle pulse on the phase 2N-1 -> 0 advance while LOCKED.
- rev_cnt  output  REV_W  revolutions counted while LOCKED.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Code convention: counter shifts left with inverted MSB fed into LSB.
  - Sequence: 0000(0), 0001(1), 0011(2), 0111(3), 1111(4), 1110(5), 1100(6), 1000(7).
  - Phase k < N: the low k bits are 1.
  - Phase k >= N: the high 2N-k bits are 1.
  - Any other pattern is illegal.
- Timing: all outputs are registered. Sample c(t) at edge t; outputs reflect c(t) vs prev_q = c(t-1) after edge t (latency 1).
- Reset values (applied at the edge with reset=1, overrides everything):
  - phase_idx=0, phase_onehot=0, phase_valid=0, locked=0.
  - err_pulse=0, err_sticky=0, wrap_pulse=0, rev_cnt=0.
  - prev_q=0, good_cnt=0, state=SEARCH.
- Illegal code: phase_valid=0, phase_onehot=0, phase_idx holds its last value.
- Transition classes (c(t) vs prev_q):
  - Step: c(t) is the Johnson successor of prev_q.
  - Hold: c(t) == prev_q.
  - Bad: anything else, including any legal backward or skipped move.
- State machine:
  - SEARCH (no reference):
    - Legal code -> TRACK, good_cnt=0.
    - Illegal code -> stay in SEARCH with err_pulse.
    - No transition checks are made in SEARCH.
  - TRACK:
    - Step -> good_cnt+1; when good_cnt reaches LOCK_STEPS -> LOCKED, with locked=1 from the same edge.
    - Hold with ALLOW_HOLD=1 -> no change.
    - Hold with ALLOW_HOLD=0, or Bad with a legal code -> err_pulse, good_cnt=0, stay in TRACK (c(t) becomes the new reference).
    - Illegal code -> err_pulse -> SEARCH.
  - LOCKED:
    - Step or allowed Hold -> stay.
    - Bad transition or disallowed Hold -> err_pulse -> TRACK, good_cnt=0.
    - Illegal code -> err_pulse -> SEARCH.
- Revolutions:
  - In LOCKED, a Step from phase 2N-1 to 0 asserts wrap_pulse for 1 cycle and increments rev_cnt modulo 2^REV_W.
  - The step that enters LOCKED does not wrap-count, even if it is 7->0.
  - rev_cnt holds its value on loss of lock; only reset clears it.
- err_sticky:
  - Set by any err_pulse.
  - Cleared by err_clr.
  - Simultaneous new error and err_clr -> err_sticky stays 1.
- prev_q loads count every non-reset cycle, whether the code is legal or not.

Decomposition:
- Shared package johnson_pkg holds:
  - state enum {SEARCH, TRACK, LOCKED};
  - function johnson_next(code) giving the successor code;
  - function johnson_legal(code);
  - function johnson_idx(code) giving the phase index.
- One natural sub-module: johnson_code_check, purely combinational. It outputs legal, idx, onehot and is_step(prev, cur), and is instantiated once.

Test Plan:
- Reset for 3 cycles, then feed the counter sequence 0000, 0001, 0011, 0111, 1111 -> phase_idx 0, 1, 2, 3, 4; phase_onehot 0x01..0x10; locked rises on the edge sampling 1111; err_sticky=0.
- Continue the sequence 1110, 1100, 1000, 0000 while LOCKED -> wrap_pulse exactly 1 cycle on the 0000 sample; rev_cnt=1; after two more full revolutions, rev_cnt=3.
- Inject 0101 while LOCKED -> phase_valid=0, phase_onehot=0, err_pulse 1 cycle, err_sticky=1, locked=0, state SEARCH. The next legal code enters TRACK; lock returns after 4 Steps.
- Jump 0011 -> 1111 while LOCKED -> err_pulse, locked=0, phase_idx=4, no SEARCH visit; rev_cnt unchanged.
- Hold 0011 for 3 cycles:
  - ALLOW_HOLD=1 -> no error, locked stays 1;
  - ALLOW_HOLD=0 -> err_pulse on the first repeat, locked=0.
- Assert reset mid-revolution while LOCKED with rev_cnt=5 -> all outputs at reset values the next edge. Separately, err_clr asserted in the same cycle as an illegal code -> err_sticky remains 1; err_clr alone on a later cycle -> err_sticky=0.
